alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Multi-cycle controller that shares the single 4-bit ALU datapath (add/sub/and/xor) between two requesters. Each request carries operands and an opcode. The block arbitrates round-robin, latches the winner's request, and drives the ALU inputs for a programmable settle interval. It then samples the ALU result and returns it with the requester's ID. It sits between the instruction-issue logic and the combinational ALU.

## Interface
- SETTLE, 2: cycles the ALU inputs are held before the result is sampled; legal range 1..15.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a, req0_b  in  4 each  requester 0 operands.
- req0_op  in  2  requester 0 opcode: 00 add, 01 sub (A−B), 10 and, 11 xor.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- alu_a, alu_b  out  4 each  operands driven to the ALU.
- alu_s  out  2  opcode driven to the ALU select.
- alu_r  in  4  ALU result (combinational from alu_a/alu_b/alu_s).
- rsp_valid  out  1  one-cycle pulse; rsp_data/rsp_id valid.
- rsp_data  out  4  registered ALU result.
- rsp_id  out  1  requester that owns rsp_data.
- busy  out  1  high in EXEC and RESP.

## Operation
- **States:**
  - IDLE: accepts requests.
  - EXEC: ALU inputs held, settle counter running.
  - RESP: rsp_valid high.
- **Handshake:** a request is accepted when reqN_valid && reqN_ready.
  - reqN_ready is asserted combinationally, only in IDLE, only for the granted requester, and only while its valid is high.
  - At most one ready is high per cycle.
- **Requester obligations:** hold valid until accepted. Operands and op must be stable while valid.
- **Arbitration:**
  - One valid: grant it.
  - Both valid: grant the requester not granted last.
  - The last-grant pointer updates on acceptance. Reset value favours req0.
- **On acceptance (IDLE→EXEC):**
  - alu_a/alu_b/alu_s are loaded from the winner.
  - The ID is latched.
  - The settle counter loads SETTLE−1.
  - Requester inputs are ignored from then on; changes after acceptance have no effect.
- **EXEC:**
  - Counter decrements each cycle.
  - On the cycle the counter is 0, rsp_data <= alu_r and rsp_id <= latched ID at the clock edge. State moves to RESP.
- **RESP:**
  - rsp_valid = 1 for exactly one cycle, then IDLE.
  - No backpressure on the response; the consumer must take it that cycle.
- **Holding behaviour:**
  - alu_a/alu_b/alu_s hold their last values in RESP and IDLE; they change only on acceptance.
  - rsp_data/rsp_id hold their last values after RESP.
- **Arithmetic:** modulo 16 per the ALU. Sub wraps, e.g. 3−5 = 0xE. No carry or overflow is returned.
- **Reset (rst_n low at a clock edge):**
  - State goes to IDLE. Counter goes to 0.
  - All outputs go to 0: readys, alu_a, alu_b, alu_s, rsp_valid, rsp_data, rsp_id, busy.
  - The pointer returns to favour req0.
- **Reset mid-operation:** reset during EXEC or RESP aborts the operation. No rsp_valid is produced for it, and the requester must reissue.

## Timing
- Acceptance in cycle T. EXEC occupies T+1 .. T+SETTLE. rsp_valid is high in T+SETTLE+1.
- Earliest next acceptance is T+SETTLE+2.
- Throughput is one operation per SETTLE+2 cycles.
- busy is high exactly from T+1 through T+SETTLE+1.
- A request that is valid while the block is busy waits. Its ready is 0 until IDLE.
- With both requesters held valid continuously, grants alternate 0,1,0,1.
- req ready has a combinational path from reqN_valid. All other outputs are registered.

## Test plan (SETTLE=2)
- **Basic add:** after reset, req0 op=00, A=7, B=5, valid in cycle T.
  - req0_ready=1 in T.
  - alu_a/alu_b/alu_s = 7/5/00 from T+1.
  - rsp_valid=1 in T+3 with rsp_data=0xC, rsp_id=0. busy high T+1..T+3.
- **Subtract with wrap:** req1 op=01, A=3, B=5 alone → rsp_data=0xE, rsp_id=1.
- **Simultaneous requests after reset:** req0 op=10, A=0xC, B=0xA and req1 op=11, A=0xC, B=0xA.
  - req0 granted first → rsp 0x8, id 0.
  - req1 accepted the cycle after that RESP → rsp 0x6, id 1.
  - req1_ready stays 0 throughout req0's operation.
- **Fairness:** both valid continuously for 4 operations.
  - rsp_id sequence is 0,1,0,1.
  - Response spacing is 4 cycles.
- **Operands changed after acceptance:** change req0_a from 7 to 1 in T+1 (same op as basic add) → rsp_data still 0xC.
- **Reset mid-operation:** assert rst_n=0 in T+1 during EXEC.
  - No rsp_valid follows.
  - All outputs are 0 after the edge.
  - With both requesters valid afterwards, req0 is granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational 4-bit ALU between two requesters. An idle
//   block grants one requester (round-robin when both are pending),
//   latches its operands/opcode onto the ALU inputs, waits SETTLE cycles,
//   registers the ALU result and presents it for one cycle with the
//   owner's ID.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   reqN_valid/ready      request handshake (ready is combinational)
//   reqN_a, reqN_b        4-bit operands
//   reqN_op               00 add, 01 sub (A-B), 10 and, 11 xor
//   alu_a, alu_b, alu_s   registered operands/opcode to the ALU
//   alu_r                 ALU result (combinational from alu_a/b/s)
//   rsp_valid             one-cycle response strobe
//   rsp_data, rsp_id      registered result and owning requester
//   busy                  high while executing or responding
module alu_arbiter #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_s,
  input  logic [3:0] alu_r,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       rsp_id,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  // last_q = 1 means req1 was granted last; resetting to 1 makes req0 win
  // the first tie.
  logic       last_q, last_d;
  logic       id_q, id_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [1:0] alu_s_q, alu_s_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic       rsp_id_q, rsp_id_d;

  logic       gnt_any;
  logic       gnt_id;

  // Grant decision: only in IDLE; a tie goes to the requester not served last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = ~last_q;
      end else if (req0_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_any & ~gnt_id;
  assign req1_ready = gnt_any &  gnt_id;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    id_d       = id_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_s_d    = alu_s_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = EXEC;
          cnt_d   = CNT_LOAD;
          last_d  = gnt_id;
          id_d    = gnt_id;
          alu_a_d = gnt_id ? req1_a  : req0_a;
          alu_b_d = gnt_id ? req1_b  : req0_b;
          alu_s_d = gnt_id ? req1_op : req0_op;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          rsp_data_d = alu_r;
          rsp_id_d   = id_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      alu_a_q    <= 4'd0;
      alu_b_q    <= 4'd0;
      alu_s_q    <= 2'd0;
      rsp_data_q <= 4'd0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      id_q       <= id_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_s_q    <= alu_s_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic [3:0] alu_a, alu_b, alu_r, rsp_data;
  logic [1:0] alu_s;
  logic       rsp_valid, rsp_id, busy;

  bit   [1:0] v;
  logic [3:0] ra [2];
  logic [3:0] rb [2];
  logic [1:0] rop [2];

  int n_cmp = 0;
  int n_bad = 0;

  assign req0_valid = v[0];
  assign req1_valid = v[1];
  assign req0_a = ra[0];
  assign req0_b = rb[0];
  assign req0_op = rop[0];
  assign req1_a = ra[1];
  assign req1_b = rb[1];
  assign req1_op = rop[1];

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
    int r;
    case (op)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b) + 16;
      2'd2:    r = int'(a & b);
      default: r = int'(a ^ b);
    endcase
    return 4'(r % 16);
  endfunction

  // External combinational ALU
  always_comb alu_r = ref_alu(alu_a, alu_b, alu_s);

  alu_arbiter #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_r(alu_r),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit val, input logic [3:0] a,
                         input logic [3:0] b, input logic [1:0] op);
    v[i] = val; ra[i] = a; rb[i] = b; rop[i] = op;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    v = 2'b00;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 4'd0, 4'd0, 2'd0);
    apply_reset;
    n_cmp++;
    if ({req0_ready, req1_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_data, rsp_id, busy} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required all zero",
               {req0_ready, req1_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_data, rsp_id, busy});
    end
  endtask

  // One isolated operation from requester id; late_a is written to the
  // requester's A input right after acceptance and must have no effect.
  task automatic issue_single(input string tag, input int id, input logic [3:0] a,
                              input logic [3:0] b, input logic [1:0] op,
                              input logic [3:0] late_a, input logic [3:0] exp);
    logic [1:0] rdy;
    set_req(id, 1'b1, a, b, op);
    set_req(1 - id, 1'b0, 4'd0, 4'd0, 2'd0);
    #1;
    rdy = {req1_ready, req0_ready};
    n_cmp++;
    if (rdy !== (2'b01 << id)) begin
      n_bad++; $display("FAIL %s_ready_T: got %b required %b", tag, rdy, 2'b01 << id);
    end
    tick; // T+1
    n_cmp++;
    if ({alu_a, alu_b, alu_s, busy, rsp_valid} !== {a, b, op, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL %s_T1: got a=%h b=%h s=%h busy=%b rv=%b required a=%h b=%h s=%h busy=1 rv=0",
               tag, alu_a, alu_b, alu_s, busy, rsp_valid, a, b, op);
    end
    v[id] = 1'b0;
    ra[id] = late_a;
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_bad++; $display("FAIL %s_ready_busy: got %b required 00", tag, {req1_ready, req0_ready});
    end
    tick; // T+2
    n_cmp++;
    if ({alu_a, busy, rsp_valid} !== {a, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL %s_T2: got a=%h busy=%b rv=%b required a=%h busy=1 rv=0",
                        tag, alu_a, busy, rsp_valid, a);
    end
    tick; // T+3
    n_cmp++;
    if ({rsp_valid, rsp_data, rsp_id, busy} !== {1'b1, exp, id[0], 1'b1}) begin
      n_bad++; $display("FAIL %s_rsp: got rv=%b data=%h id=%b busy=%b required rv=1 data=%h id=%0d busy=1",
                        tag, rsp_valid, rsp_data, rsp_id, busy, exp, id);
    end
    tick; // T+4
    n_cmp++;
    if ({rsp_valid, busy, rsp_data, rsp_id, alu_a} !== {1'b0, 1'b0, exp, id[0], a}) begin
      n_bad++; $display("FAIL %s_hold: got rv=%b busy=%b data=%h id=%b a=%h required rv=0 busy=0 data=%h id=%0d a=%h",
                        tag, rsp_valid, busy, rsp_data, rsp_id, alu_a, exp, id, a);
    end
  endtask

  task automatic test_basic_add;
    issue_single("add", 0, 4'd7, 4'd5, 2'b00, 4'd7, 4'hC);
  endtask

  task automatic test_sub_wrap;
    issue_single("sub", 1, 4'd3, 4'd5, 2'b01, 4'd3, 4'hE);
  endtask

  task automatic test_late_change;
    issue_single("late", 0, 4'd7, 4'd5, 2'b00, 4'd1, 4'hC);
  endtask

  task automatic test_simultaneous;
    apply_reset;
    set_req(0, 1'b1, 4'hC, 4'hA, 2'b10);
    set_req(1, 1'b1, 4'hC, 4'hA, 2'b11);
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_bad++; $display("FAIL sim_first_grant: got %b required 01", {req1_ready, req0_ready});
    end
    tick;          // T+1
    v[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_cmp++;
      if (req1_ready !== 1'b0) begin
        n_bad++; $display("FAIL sim_req1_wait: got %b required 0 at T+%0d", req1_ready, k);
      end
      if (k == 3) begin
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 4'h8, 1'b0}) begin
          n_bad++; $display("FAIL sim_rsp0: got rv=%b data=%h id=%b required rv=1 data=8 id=0",
                            rsp_valid, rsp_data, rsp_id);
        end
      end
      tick;
    end
    // T+4: back in IDLE
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      n_bad++; $display("FAIL sim_second_grant: got %b required 10", {req1_ready, req0_ready});
    end
    tick;
    v[1] = 1'b0;
    tick;
    tick;
    n_cmp++;
    if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 4'h6, 1'b1}) begin
      n_bad++; $display("FAIL sim_rsp1: got rv=%b data=%h id=%b required rv=1 data=6 id=1",
                        rsp_valid, rsp_data, rsp_id);
    end
    tick;
  endtask

  task automatic test_fairness;
    int cyc_log[$];
    bit id_log[$];
    apply_reset;
    set_req(0, 1'b1, 4'd1, 4'd2, 2'b00);
    set_req(1, 1'b1, 4'd5, 4'd3, 2'b11);
    for (int c = 0; c < 60 && cyc_log.size() < 4; c++) begin
      tick;
      if (rsp_valid === 1'b1) begin
        cyc_log.push_back(c);
        id_log.push_back(rsp_id);
      end
    end
    v = 2'b00;
    n_cmp++;
    if (cyc_log.size() != 4) begin
      n_bad++; $display("FAIL fair_count: got %0d responses required 4 within 60 cycles", cyc_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (id_log[k] !== k[0]) begin
          n_bad++; $display("FAIL fair_id%0d: got %b required %b", k, id_log[k], k[0]);
        end
        if (k > 0) begin
          n_cmp++;
          if (cyc_log[k] - cyc_log[k-1] != SETTLE + 2) begin
            n_bad++; $display("FAIL fair_spacing%0d: got %0d required %0d", k,
                              cyc_log[k] - cyc_log[k-1], SETTLE + 2);
          end
        end
      end
    end
    for (int c = 0; c < 4; c++) tick;
  endtask

  task automatic test_reset_mid_op;
    apply_reset;
    set_req(0, 1'b1, 4'd7, 4'd5, 2'b00);
    set_req(1, 1'b0, 4'd0, 4'd0, 2'b00);
    tick;          // T+1, EXEC; req0 now recorded as last grant
    v = 2'b00;
    rst_n = 1'b0;
    tick;
    n_cmp++;
    if ({req0_ready, req1_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_data, rsp_id, busy} !== 19'd0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got %b required all zero",
               {req0_ready, req1_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_data, rsp_id, busy});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      n_cmp++;
      if ({rsp_valid, busy} !== 2'b00) begin
        n_bad++; $display("FAIL midrst_no_rsp: got rv=%b busy=%b required 0/0 cycle %0d",
                          rsp_valid, busy, c);
      end
    end
    set_req(0, 1'b1, 4'd2, 4'd2, 2'b00);
    set_req(1, 1'b1, 4'd2, 4'd2, 2'b01);
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_bad++; $display("FAIL midrst_grant: got %b required 01", {req1_ready, req0_ready});
    end
    tick;
    v = 2'b00;
    for (int c = 0; c < 4; c++) tick;
  endtask

  // Random traffic against a transaction-level model: the block is either
  // free or busy for a known number of cycles after each acceptance.
  task automatic test_random;
    int         m_busy;
    bit         m_last;
    bit         e_r0, e_r1;
    int         g;
    logic [3:0] e_a, e_b, e_rd, pend_d;
    logic [1:0] e_s;
    logic       e_rid, pend_id;
    int         n_acc;
    apply_reset;
    m_busy = 0; m_last = 1'b1; n_acc = 0;
    e_a = 4'd0; e_b = 4'd0; e_s = 2'd0; e_rd = 4'd0; e_rid = 1'b0;
    pend_d = 4'd0; pend_id = 1'b0;
    for (int c = 0; c < 400; c++) begin
      n_cmp++;
      if ({busy, rsp_valid} !== {m_busy > 0, m_busy == 1}) begin
        n_bad++; $display("FAIL rnd_ctrl c%0d: got busy=%b rv=%b required busy=%b rv=%b",
                          c, busy, rsp_valid, m_busy > 0, m_busy == 1);
      end
      n_cmp++;
      if ({alu_a, alu_b, alu_s, rsp_data, rsp_id} !== {e_a, e_b, e_s, e_rd, e_rid}) begin
        n_bad++; $display("FAIL rnd_data c%0d: got a=%h b=%h s=%h rd=%h id=%b required a=%h b=%h s=%h rd=%h id=%b",
                          c, alu_a, alu_b, alu_s, rsp_data, rsp_id, e_a, e_b, e_s, e_rd, e_rid);
      end
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && $urandom_range(2) == 0)
          set_req(i, 1'b1, 4'($urandom), 4'($urandom), 2'($urandom));
      end
      #1;
      e_r0 = (m_busy == 0) && v[0] && (!v[1] || m_last);
      e_r1 = (m_busy == 0) && v[1] && (!v[0] || !m_last);
      n_cmp++;
      if ({req1_ready, req0_ready} !== {e_r1, e_r0}) begin
        n_bad++; $display("FAIL rnd_ready c%0d: got %b required %b", c,
                          {req1_ready, req0_ready}, {e_r1, e_r0});
      end
      tick;
      if (e_r0 || e_r1) begin
        g = e_r1 ? 1 : 0;
        m_last = e_r1;
        m_busy = SETTLE + 1;
        e_a = ra[g]; e_b = rb[g]; e_s = rop[g];
        pend_d = ref_alu(ra[g], rb[g], rop[g]);
        pend_id = e_r1;
        v[g] = 1'b0;
        n_acc++;
      end else if (m_busy > 0) begin
        m_busy--;
      end
      if (m_busy == 1) begin
        e_rd = pend_d;
        e_rid = pend_id;
      end
    end
    v = 2'b00;
    n_cmp++;
    if (n_acc < 20) begin
      n_bad++; $display("FAIL rnd_progress: got %0d acceptances required at least 20", n_acc);
    end
    for (int c = 0; c < 5; c++) tick;
  endtask

  initial begin
    rst_n = 1'b0;
    v = 2'b00;
    test_reset;
    test_basic_add;
    test_sub_wrap;
    test_late_change;
    test_simultaneous;
    test_fairness;
    test_reset_mid_op;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
